// File: rtl/tdc_delayline_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | tdc_delayline_ctrl_pkg                                               |
// | Shared FSM state type and tap/fine-width helpers for the TDC block.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package tdc_delayline_ctrl_pkg;

  localparam int c_taps_per_carry4 = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_LATCH  = 3'd2,
    ST_FILTER = 3'd3,
    ST_ENCODE = 3'd4,
    ST_EMIT   = 3'd5,
    ST_DRAIN  = 3'd6
  } state_t;

  function automatic int taps_of(input int ncarry4);
    return c_taps_per_carry4 * ncarry4;
  endfunction

  // Fine code spans 0..TAPS inclusive.
  function automatic int fine_w_of(input int ncarry4);
    return $clog2(taps_of(ncarry4) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_delayline_ctrl_if.sv
// +----------------------------------------------------------------------+
// | tdc_delayline_ctrl_if                                                |
// | Event word valid/ready channel from the sequencer to readout FIFO.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface tdc_delayline_ctrl_if #(
  parameter int COARSE_W = 16,
  parameter int FINE_W   = 4
);
  logic                ev_valid;
  logic                ev_ready;
  logic [COARSE_W-1:0] ev_coarse;
  logic [FINE_W-1:0]   ev_fine;

  modport master (output ev_valid, output ev_coarse, output ev_fine, input ev_ready);
  modport slave  (input ev_valid, input ev_coarse, input ev_fine, output ev_ready);
endinterface

`default_nettype wire

// File: rtl/tdc_delayline_ctrl_therm_encoder.sv
// +----------------------------------------------------------------------+
// | tdc_delayline_ctrl_therm_encoder                                     |
// | Combinational popcount of a thermometer snapshot into a fine code.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tdc_delayline_ctrl_therm_encoder #(
  parameter int TAPS   = 8,
  parameter int FINE_W = $clog2(TAPS + 1)
) (
  input  logic [TAPS-1:0]   i_therm,
  output logic [FINE_W-1:0] o_fine
);

  // Counting ones rather than locating the edge tolerates residual bubbles.
  always_comb begin
    o_fine = '0;
    for (int i = 0; i < TAPS; i++) begin
      o_fine = o_fine + FINE_W'(i_therm[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tdc_delayline_ctrl.sv
// +----------------------------------------------------------------------+
// | tdc_delayline_ctrl                                                   |
// | Arm/capture/re-arm sequencer for a CARRY4 tapped delay line.         |
// | Optional majority bubble filter: define BUBBLE_FILTER_EN.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tdc_delayline_ctrl
  import tdc_delayline_ctrl_pkg::*;
#(
  parameter  int NCARRY4     = 2,
  parameter  int COARSE_W    = 16,
  parameter  int DEAD_CYCLES = 4,
  localparam int TAPS        = taps_of(NCARRY4),
  localparam int FINE_W      = fine_w_of(NCARRY4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [TAPS-1:0]       taps,
  output logic                  line_en,
  output logic                  busy,
  tdc_delayline_ctrl_if.master  ev
);

  localparam int               DEAD_W      = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] c_dead_last = DEAD_W'(DEAD_CYCLES - 1);

  state_t              r_state;
  logic [COARSE_W-1:0] r_coarse_cnt;
  logic [COARSE_W-1:0] r_ev_coarse;
  logic [FINE_W-1:0]   r_ev_fine;
  logic [DEAD_W-1:0]   r_dead;
  logic [TAPS-1:0]     r_snap;
  logic                r_line_en;
  logic                r_ev_valid;
  logic                r_busy;
  logic [FINE_W-1:0]   w_fine;
  logic                w_dead_done;

  assign w_dead_done  = (r_dead == c_dead_last);
  assign line_en      = r_line_en;
  assign busy         = r_busy;
  assign ev.ev_valid  = r_ev_valid;
  assign ev.ev_coarse = r_ev_coarse;
  assign ev.ev_fine   = r_ev_fine;

`ifdef BUBBLE_FILTER_EN
  // Virtual neighbours: a 1 before the first tap, a 0 past the last.
  logic [TAPS+1:0] w_ext;
  logic [TAPS-1:0] w_filt;
  assign w_ext = {1'b0, r_snap, 1'b1};
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_filt
    assign w_filt[gi] = (w_ext[gi] & w_ext[gi+1]) | (w_ext[gi+1] & w_ext[gi+2]) |
                        (w_ext[gi] & w_ext[gi+2]);
  end
`endif

  tdc_delayline_ctrl_therm_encoder #(
    .TAPS   (TAPS),
    .FINE_W (FINE_W)
  ) u_enc (
    .i_therm (r_snap),
    .o_fine  (w_fine)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_coarse_cnt <= '0;
    else     r_coarse_cnt <= r_coarse_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_line_en   <= 1'b0;
      r_ev_valid  <= 1'b0;
      r_ev_coarse <= '0;
      r_ev_fine   <= '0;
      r_busy      <= 1'b0;
      r_dead      <= '0;
      r_snap      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Flush the line before the first arm.
          if (enable) begin
            r_state <= ST_DRAIN;
            r_dead  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (taps[0]) begin
            r_state     <= ST_LATCH;
            r_line_en   <= 1'b0;
            r_snap      <= taps;
            r_ev_coarse <= r_coarse_cnt;
          end else if (!enable) begin
            r_state   <= ST_IDLE;
            r_line_en <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        ST_LATCH: begin
`ifdef BUBBLE_FILTER_EN
          r_state <= ST_FILTER;
`else
          r_state <= ST_ENCODE;
`endif
        end
`ifdef BUBBLE_FILTER_EN
        ST_FILTER: begin
          r_snap  <= w_filt;
          r_state <= ST_ENCODE;
        end
`endif
        ST_ENCODE: begin
          r_ev_fine  <= w_fine;
          r_ev_valid <= 1'b1;
          r_state    <= ST_EMIT;
        end
        ST_EMIT: begin
          if (ev.ev_ready) begin
            r_ev_valid <= 1'b0;
            r_dead     <= '0;
            r_state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!w_dead_done) begin
            r_dead <= r_dead + 1'b1;
          end else if (taps == '0) begin
            if (enable) begin
              r_state   <= ST_ARM;
              r_line_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_line_en  <= 1'b0;
          r_ev_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tdc_delayline_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_tdc_delayline_ctrl                                                |
// | Self-checking bench: 16-bit and 4-bit coarse instances, same stimulus.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tdc_delayline_ctrl;

  localparam int NCARRY4     = 2;
  localparam int TAPS        = 8;
  localparam int FINE_W      = 4;
  localparam int DEAD_CYCLES = 4;
  localparam int CW_A        = 16;
  localparam int CW_B        = 4;
`ifdef BUBBLE_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic            clk    = 1'b0;
  logic            rst    = 1'b1;
  logic            enable = 1'b0;
  logic            ready  = 1'b0;
  logic [TAPS-1:0] taps   = '0;
  logic            line_en_a, busy_a, line_en_b, busy_b;
  int              cyc;
  int              npass = 0;
  int              ntot  = 0;

  tdc_delayline_ctrl_if #(.COARSE_W(CW_A), .FINE_W(FINE_W)) ev_a ();
  tdc_delayline_ctrl_if #(.COARSE_W(CW_B), .FINE_W(FINE_W)) ev_b ();
  assign ev_a.ev_ready = ready;
  assign ev_b.ev_ready = ready;

  tdc_delayline_ctrl #(.NCARRY4(NCARRY4), .COARSE_W(CW_A), .DEAD_CYCLES(DEAD_CYCLES)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .taps(taps),
    .line_en(line_en_a), .busy(busy_a), .ev(ev_a));
  tdc_delayline_ctrl #(.NCARRY4(NCARRY4), .COARSE_W(CW_B), .DEAD_CYCLES(DEAD_CYCLES)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .taps(taps),
    .line_en(line_en_b), .busy(busy_b), .ev(ev_b));

  always #5 clk = ~clk;

  // Reference time base: clock edges elapsed since reset.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popc(input logic [TAPS-1:0] v);
    int n = 0;
    for (int i = 0; i < TAPS; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [TAPS-1:0] bubble_fix(input logic [TAPS-1:0] v);
    logic [TAPS-1:0] o;
    for (int i = 0; i < TAPS; i++) begin
      int lo, hi;
      lo = (i == 0) ? 1 : int'(v[i-1]);
      hi = (i == TAPS - 1) ? 0 : int'(v[i+1]);
      o[i] = (lo + int'(v[i]) + hi) >= 2;
    end
    return o;
  endfunction

  function automatic int expected_fine(input logic [TAPS-1:0] v);
`ifdef BUBBLE_FILTER_EN
    return popc(bubble_fix(v));
`else
    return popc(v);
`endif
  endfunction

  task automatic wait_arm();
    int k = 0;
    while (!line_en_a && k < 40) begin
      tick();
      k++;
    end
    chk("arm_reached", {28'd0, line_en_a, line_en_b, busy_a, busy_b}, 32'hF);
  endtask

  task automatic arm_idle(input int n);
    for (int k = 0; k < n; k++) begin
      chk("arm_hold", {30'd0, line_en_a, line_en_b}, 32'h3);
      tick();
    end
  endtask

  // Hit issued in the current ARM cycle; stall = cycles with ready low in EMIT,
  // hold = DRAIN cycles with taps still nonzero, en_after = enable during EMIT.
  task automatic do_event(input logic [TAPS-1:0] pat, input int stall, input int hold,
                          input logic en_after);
    int exp_c, exp_f, d, exp_drain;
    taps  = pat;
    ready = 1'b0;
    exp_c = cyc;
    exp_f = expected_fine(pat);
    for (int k = 1; k < LAT; k++) begin
      tick();
      chk("pipe_gap", {26'd0, ev_a.ev_valid, ev_b.ev_valid, line_en_a, line_en_b, busy_a, busy_b},
          32'h3);
    end
    tick();
    enable = en_after;
    chk("valid_at_lat", {30'd0, ev_a.ev_valid, ev_b.ev_valid}, 32'h3);
    chk("coarse_a", {16'd0, ev_a.ev_coarse}, exp_c & 32'hFFFF);
    chk("coarse_b", {28'd0, ev_b.ev_coarse}, exp_c & 32'hF);
    chk("fine", {24'd0, ev_a.ev_fine, ev_b.ev_fine}, (exp_f << 4) | exp_f);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_hold", {ev_a.ev_valid, ev_b.ev_valid, line_en_a, ev_a.ev_fine, ev_b.ev_coarse,
          ev_a.ev_coarse[15:0], 5'd0},
          {3'b110, 4'(exp_f), 4'(exp_c), 16'(exp_c), 5'd0});
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("valid_drop", {30'd0, ev_a.ev_valid, ev_b.ev_valid}, 32'h0);
    for (int k = 0; k < hold; k++) begin
      chk("drain_hold", {28'd0, line_en_a, line_en_b, busy_a, busy_b}, 32'h3);
      tick();
    end
    taps = '0;
    d = 0;
    while (!line_en_a && busy_a && d < 40) begin
      chk("drain_valid", {30'd0, ev_a.ev_valid, ev_b.ev_valid}, 32'h0);
      tick();
      d++;
    end
    exp_drain = (hold + 1 > DEAD_CYCLES) ? hold + 1 : DEAD_CYCLES;
    chk("drain_len", hold + d, exp_drain);
    chk("post_drain", {28'd0, line_en_a, line_en_b, busy_a, busy_b},
        en_after ? 32'hF : 32'h0);
  endtask

  initial begin
    logic [TAPS-1:0] pat;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {ev_a.ev_valid, ev_b.ev_valid, line_en_a, line_en_b, busy_a, busy_b,
        ev_a.ev_fine, ev_b.ev_fine, ev_a.ev_coarse[15:0], 2'd0}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_hold", {28'd0, line_en_a, line_en_b, busy_a, busy_b}, 32'h0);
    end

    enable = 1'b1;
    wait_arm();
    arm_idle(5);
    do_event(8'h07, 0, 0, 1'b1);
    do_event(8'hFF, 0, 10, 1'b1);
    do_event(8'h03, 20, 0, 1'b1);
    do_event(8'b0001_1011, 1, 2, 1'b1);

    // Land a hit on the 4-bit counter's terminal value, then one just past the wrap.
    for (int k = 0; k < 20 && (cyc % 16) != 15; k++) begin
      chk("arm_wait_wrap", {31'd0, line_en_a}, 32'h1);
      tick();
    end
    do_event(8'h0F, 0, 0, 1'b1);
    do_event(8'h01, 0, 0, 1'b1);

    for (int e = 0; e < 30; e++) begin
      pat = TAPS'($urandom) | TAPS'(1);
      arm_idle(int'($urandom_range(0, 5)));
      do_event(pat, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b1);
    end

    enable = 1'b0;
    tick();
    chk("arm_disable", {28'd0, line_en_a, line_en_b, busy_a, busy_b}, 32'h0);

    enable = 1'b1;
    wait_arm();
    do_event(8'h3F, 2, 1, 1'b0);

    enable = 1'b1;
    wait_arm();
    taps = 8'h1F;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid", {ev_a.ev_valid, ev_b.ev_valid, line_en_a, line_en_b, busy_a, busy_b,
        ev_a.ev_fine, ev_b.ev_fine, ev_a.ev_coarse[15:0], 2'd0}, 32'h0);
    taps   = '0;
    enable = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst_no_event", {28'd0, ev_a.ev_valid, ev_b.ev_valid, busy_a, busy_b}, 32'h0);
    end
    enable = 1'b1;
    wait_arm();
    do_event(8'h7F, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire
